// File: rtl/cross_product_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cross_product_arbiter_if
// Description : Request/grant and tagged-response bundle for the shared
//               cross-product unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface cross_product_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int COORD_W = 10
);
    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RES_W = 2 * COORD_W + 2;

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           lock;
    logic [NUM_REQ*2*COORD_W-1:0] op_p1;
    logic [NUM_REQ*2*COORD_W-1:0] op_p2;
    logic [NUM_REQ*2*COORD_W-1:0] op_ref;
    logic [NUM_REQ-1:0]           gnt;
    logic                         rsp_valid;
    logic [IDW-1:0]               rsp_id;
    logic signed [RES_W-1:0]      rsp_result;
    logic                         rsp_pos;
    logic                         rsp_zero;

    modport master (
        output req, lock, op_p1, op_p2, op_ref,
        input  gnt, rsp_valid, rsp_id, rsp_result, rsp_pos, rsp_zero
    );

    modport slave (
        input  req, lock, op_p1, op_p2, op_ref,
        output gnt, rsp_valid, rsp_id, rsp_result, rsp_pos, rsp_zero
    );
endinterface
`default_nettype wire

// File: rtl/cross_product_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cross_product_arbiter
// Description : Round-robin/lockable arbiter sharing a 2-stage signed
//               cross-product pipeline, (P1-R)x(P2-R), with tagged responses.
// Revision    : 1.0 - initial release
// ============================================================================
module cross_product_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int COORD_W = 10
) (
    input  wire logic              clk,
    input  wire logic              reset,
    cross_product_arbiter_if.slave bus
);
    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RES_W = 2 * COORD_W + 2;
    localparam int PW    = 2 * COORD_W;
    localparam int DW    = COORD_W + 1;

    localparam logic [IDW:0] c_num_req = (IDW + 1)'(NUM_REQ);

    logic [PW-1:0] w_p1  [NUM_REQ];
    logic [PW-1:0] w_p2  [NUM_REQ];
    logic [PW-1:0] w_ref [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_p1[gi]  = bus.op_p1[gi*PW +: PW];
            assign w_p2[gi]  = bus.op_p2[gi*PW +: PW];
            assign w_ref[gi] = bus.op_ref[gi*PW +: PW];
        end
    endgenerate

    logic [IDW-1:0] r_rr_ptr;
    logic           r_owner_valid;
    logic [IDW-1:0] r_owner;

    logic           w_owner_active;
    logic           w_found;
    logic [IDW-1:0] w_sel;
    logic [IDW:0]   w_scan;
    logic [IDW:0]   w_sel_inc;
    logic [IDW-1:0] w_next_ptr;
    logic [NUM_REQ-1:0] w_gnt;

    assign w_owner_active = r_owner_valid && bus.req[r_owner];

    // Locked owner wins outright; otherwise scan circularly from r_rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_scan  = '0;
        if (w_owner_active) begin
            w_found = 1'b1;
            w_sel   = r_owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = {1'b0, r_rr_ptr} + k[IDW:0];
                if (w_scan >= c_num_req) begin
                    w_scan = w_scan - c_num_req;
                end
                if (!w_found && bus.req[w_scan[IDW-1:0]]) begin
                    w_found = 1'b1;
                    w_sel   = w_scan[IDW-1:0];
                end
            end
        end
        if (reset) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        w_gnt        = '0;
        w_gnt[w_sel] = w_found;
    end

    assign bus.gnt = w_gnt;

    always_comb begin
        w_sel_inc  = {1'b0, w_sel} + {{IDW{1'b0}}, 1'b1};
        w_next_ptr = (w_sel_inc == c_num_req) ? '0 : w_sel_inc[IDW-1:0];
    end

    // Operand differences are formed in the accept cycle so the requester may
    // change its operands immediately afterwards.
    logic [PW-1:0] w_sel_p1;
    logic [PW-1:0] w_sel_p2;
    logic [PW-1:0] w_sel_ref;
    logic [DW-1:0] w_dx1;
    logic [DW-1:0] w_dy1;
    logic [DW-1:0] w_dx2;
    logic [DW-1:0] w_dy2;

    assign w_sel_p1  = w_p1[w_sel];
    assign w_sel_p2  = w_p2[w_sel];
    assign w_sel_ref = w_ref[w_sel];

    assign w_dx1 = {1'b0, w_sel_p1[PW-1 -: COORD_W]} - {1'b0, w_sel_ref[PW-1 -: COORD_W]};
    assign w_dy1 = {1'b0, w_sel_p1[COORD_W-1:0]}    - {1'b0, w_sel_ref[COORD_W-1:0]};
    assign w_dx2 = {1'b0, w_sel_p2[PW-1 -: COORD_W]} - {1'b0, w_sel_ref[PW-1 -: COORD_W]};
    assign w_dy2 = {1'b0, w_sel_p2[COORD_W-1:0]}    - {1'b0, w_sel_ref[COORD_W-1:0]};

    logic           r_s1_valid;
    logic [IDW-1:0] r_s1_id;
    logic [DW-1:0]  r_dx1;
    logic [DW-1:0]  r_dy1;
    logic [DW-1:0]  r_dx2;
    logic [DW-1:0]  r_dy2;

    logic signed [RES_W-1:0] w_ex_dx1;
    logic signed [RES_W-1:0] w_ex_dy1;
    logic signed [RES_W-1:0] w_ex_dx2;
    logic signed [RES_W-1:0] w_ex_dy2;
    logic signed [RES_W-1:0] w_cross;

    assign w_ex_dx1 = {{(RES_W-DW){r_dx1[DW-1]}}, r_dx1};
    assign w_ex_dy1 = {{(RES_W-DW){r_dy1[DW-1]}}, r_dy1};
    assign w_ex_dx2 = {{(RES_W-DW){r_dx2[DW-1]}}, r_dx2};
    assign w_ex_dy2 = {{(RES_W-DW){r_dy2[DW-1]}}, r_dy2};

    // The true result always fits RES_W, so modular RES_W arithmetic is exact.
    assign w_cross = (w_ex_dx1 * w_ex_dy2) - (w_ex_dx2 * w_ex_dy1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_owner_valid  <= 1'b0;
            r_owner        <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_id        <= '0;
            r_dx1          <= '0;
            r_dy1          <= '0;
            r_dx2          <= '0;
            r_dy2          <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_pos    <= 1'b0;
            bus.rsp_zero   <= 1'b0;
        end else begin
            if (w_found) begin
                r_rr_ptr      <= w_next_ptr;
                r_owner_valid <= bus.lock[w_sel];
                r_owner       <= w_sel;
            end else if (r_owner_valid && !bus.req[r_owner]) begin
                r_owner_valid <= 1'b0;
            end

            r_s1_valid <= w_found;
            if (w_found) begin
                r_s1_id <= w_sel;
                r_dx1   <= w_dx1;
                r_dy1   <= w_dy1;
                r_dx2   <= w_dx2;
                r_dy2   <= w_dy2;
            end

            bus.rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                bus.rsp_id     <= r_s1_id;
                bus.rsp_result <= w_cross;
                bus.rsp_pos    <= !w_cross[RES_W-1] && (w_cross != '0);
                bus.rsp_zero   <= (w_cross == '0);
            end
        end
    end
endmodule
`default_nettype wire
